vz_tape_loader: RTL and testbench
=================================

// Module: vz_tape_loader
// PURPOSE
//  Sits between the HPS download stream and LASER310_TOP memory: parses a .VZ image (index 1),
//  writes its payload into system RAM through a req/ack port, then patches BASIC/USR pointers.
//  Holds the Z80 off the bus (cpu_hold) while loading. Runs in the 10 MHz system domain.
// PARAMETERS
//  FIFO_DEPTH  8       byte FIFO between download stream and RAM port (power of 2, >=2)
//  HDR_LEN     24      VZ header bytes: 0-3 magic, 4-20 name, 21 type, 22-23 start addr (LE)
//  PTR_END     16'h78F9 BASIC end-of-program pointer (2 bytes LE), patched for type F0
//  PTR_USR     16'h788E USR vector (2 bytes LE), patched for type F1
// PORTS
//  CLK10MHZ    in   1   system clock
//  RESET       in   1   asynchronous, active-low reset
//  dn_active   in   1   download in progress with VZ index selected
//  dn_wr       in   1   one-cycle strobe, dn_data valid
//  dn_addr     in   14  byte offset within file
//  dn_data     in   8   file byte
//  ram_req     out  1   write request, held until ram_ack
//  ram_ack     in   1   one-cycle grant; write done this cycle
//  ram_addr    out  16  write address
//  ram_data    out  8   write data
//  cpu_hold    out  1   1 = Z80 held (BUSRQ) during load/patch
//  vz_type     out  8   type byte from header (F0 BASIC, F1 binary)
//  load_done   out  1   one-cycle pulse, load + patch complete
//  load_err    out  1   sticky until next dn_active rise: FIFO overflow or addr gap
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, start/expect counters 0.
//  States: IDLE -> HDR (dn_active rise; cpu_hold=1, load_err cleared) -> DATA (offset HDR_LEN-1
//   captured) -> DRAIN (dn_active fall) -> PATCH -> DONE (one cycle, load_done=1) -> IDLE.
//  dn_active falling in HDR (short file): go to DONE, no writes, load_err=1, cpu_hold drops.
//  Sequence check: dn_addr must equal expected offset (0,1,2...); mismatch -> load_err=1, byte dropped.
//  Header bytes latched by offset; header never pushed to FIFO. vz_type updated at offset 21.
//  Data byte at offset n>=HDR_LEN pushes {addr=start+(n-HDR_LEN) mod 2^16, data} into FIFO.
//  Address arithmetic 16-bit, wraps FFFF->0000 silently.
//  FIFO: push on accepted dn_wr, pop on ram_ack; push+pop same cycle legal at any fill level
//   incl. full (count unchanged). Push while full without pop -> byte dropped, load_err=1.
//  RAM port: ram_req asserts the cycle after FIFO non-empty; addr/data stable while req high;
//   after ack, next entry may request next cycle (>=1 idle cycle between requests not required).
//  End pointer: last_addr = start + payload_len (address after final byte), 16-bit.
//  PATCH (after FIFO empty and no req pending): F0 -> write last_addr LE to PTR_END, PTR_END+1;
//   F1 -> write start LE to PTR_USR, PTR_USR+1; other type -> no patch writes.
//   Patch writes use same req/ack port, in address order.
//  cpu_hold=1 from HDR entry until the DONE cycle inclusive; 0 in IDLE.
//  dn_active re-rise during DRAIN/PATCH: ignored until IDLE reached.
//  RESET asserted mid-load: immediate return to IDLE, FIFO flushed, ram_req/cpu_hold drop
//   asynchronously; partially written RAM left as is.
// TESTING
//  F0 file, start 7AE9, 3 data bytes 11 22 33, ack 1 cycle after req -> writes 7AE9=11,7AEA=22,
//   7AEB=33, then 78F9=EC,78FA=7A; one load_done pulse; cpu_hold low after.
//  F1 file start C000, 2 bytes -> C000,C001 written, then 788E=00,788F=C0; vz_type=F1.
//  dn_wr every cycle, ram_ack stalled 20 cycles, FIFO_DEPTH=8 -> exactly 8 buffered, 9th dropped,
//   load_err=1, remaining bytes drain in order after ack resumes.
//  Start FFFE, 4 bytes -> writes FFFE,FFFF,0000,0001; F0 end pointer = 0002.
//  dn_addr jumps 30->32 -> load_err=1, byte 32 not written, load completes.
//  RESET low while FIFO holds 5 entries -> ram_req, cpu_hold 0 same cycle; after release, a new
//   download loads cleanly with load_err=0; 10-byte file -> no writes, load_err=1.

Source files
------------

// File: rtl/vz_tape_loader_if.sv
// Bundle between the HPS download stream, the tape loader and the system RAM write port.
`timescale 1ns/1ps
interface vz_tape_loader_if;
  logic        dn_active;
  logic        dn_wr;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data;
  logic        ram_req;
  logic        ram_ack;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;

  // RAM port: ram_req is the valid, ram_ack the one-cycle ready; the write completes in the
  // cycle both are high, and ram_addr/ram_data hold steady for as long as ram_req waits.
  modport master (
    output dn_active, dn_wr, dn_addr, dn_data, ram_ack,
    input  ram_req, ram_addr, ram_data
  );
  modport slave (
    input  dn_active, dn_wr, dn_addr, dn_data, ram_ack,
    output ram_req, ram_addr, ram_data
  );
endinterface

// File: rtl/vz_tape_loader.sv
// .VZ image loader: parses the 24-byte header, streams the payload into RAM through a small
// FIFO, then patches the BASIC end pointer (type F0) or USR vector (type F1).
`timescale 1ns/1ps
module vz_tape_loader #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          HDR_LEN    = 24,
  parameter logic [15:0] PTR_END    = 16'h78F9,
  parameter logic [15:0] PTR_USR    = 16'h788E
) (
  input  logic             CLK10MHZ,
  input  logic             RESET,
  vz_tape_loader_if.slave  bus,
  output logic             cpu_hold,
  output logic [7:0]       vz_type,
  output logic             load_done,
  output logic             load_err,
  output logic [2:0]       dbg_state
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [13:0] OFF_TYPE = 14'(HDR_LEN - 3);
  localparam logic [13:0] OFF_SLO  = 14'(HDR_LEN - 2);
  localparam logic [13:0] OFF_SHI  = 14'(HDR_LEN - 1);
  localparam logic [13:0] OFF_DATA = 14'(HDR_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_DRAIN = 3'd3,
    S_PATCH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_fifo_addr [FIFO_DEPTH];
  logic [7:0]    r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          r_active_q, r_req, r_err;
  logic [13:0]   r_expect;
  logic [15:0]   r_start, r_next_addr;
  logic [7:0]    r_type;
  logic [1:0]    r_pidx;

  logic          w_rise, w_fall, w_loading, w_wr_ok, w_seq_err, w_push_req;
  logic          w_pop, w_full, w_push, w_ovf, w_patch_en, w_patch_ack;
  logic [CW-1:0] w_count_nxt;
  logic [1:0]    w_pidx_nxt;
  logic [15:0]   w_patch_addr, w_patch_word;
  logic [7:0]    w_patch_data;

  assign w_rise      = bus.dn_active & ~r_active_q;
  assign w_fall      = ~bus.dn_active & r_active_q;
  assign w_loading   = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_wr_ok     = w_loading & bus.dn_wr & (bus.dn_addr == r_expect);
  assign w_seq_err   = w_loading & bus.dn_wr & (bus.dn_addr != r_expect);
  assign w_push_req  = w_wr_ok & (r_expect >= OFF_DATA);
  assign w_pop       = r_req & bus.ram_ack & (r_state != S_PATCH);
  assign w_full      = (r_count == FULL_CNT);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_ovf       = w_push_req & w_full & ~w_pop;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign w_patch_en   = (r_type == 8'hF0) || (r_type == 8'hF1);
  assign w_patch_ack  = (r_state == S_PATCH) & r_req & bus.ram_ack;
  assign w_pidx_nxt   = r_pidx + {1'b0, w_patch_ack};
  assign w_patch_addr = ((r_type == 8'hF0) ? PTR_END : PTR_USR) + {15'd0, r_pidx[0]};
  assign w_patch_word = (r_type == 8'hF0) ? r_next_addr : r_start;
  assign w_patch_data = r_pidx[0] ? w_patch_word[15:8] : w_patch_word[7:0];

  assign bus.ram_req  = r_req;
  assign bus.ram_addr = (r_state == S_PATCH) ? w_patch_addr : r_fifo_addr[r_rp];
  assign bus.ram_data = (r_state == S_PATCH) ? w_patch_data : r_fifo_data[r_rp];
  assign vz_type      = r_type;
  assign load_err     = r_err;
  assign dbg_state    = r_state;

  always_comb begin
    w_state_nxt = r_state;
    cpu_hold    = (r_state != S_IDLE);
    load_done   = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (w_rise) w_state_nxt = S_HDR;
      S_HDR: begin
        if (w_fall)                                 w_state_nxt = S_DONE;
        else if (w_wr_ok && bus.dn_addr == OFF_SHI) w_state_nxt = S_DATA;
      end
      S_DATA:  if (w_fall) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_count == '0 && !r_req) w_state_nxt = S_PATCH;
      S_PATCH: if ((!w_patch_en || r_pidx == 2'd2) && !r_req) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK10MHZ or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_active_q  <= 1'b0;
      r_expect    <= '0;
      r_start     <= '0;
      r_next_addr <= '0;
      r_type      <= '0;
      r_err       <= 1'b0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_req       <= 1'b0;
      r_pidx      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_active_q <= bus.dn_active;
      if (r_state == S_IDLE && w_rise)         r_err <= 1'b0;
      else if (w_seq_err || w_ovf)             r_err <= 1'b1;
      else if (r_state == S_HDR && w_fall)     r_err <= 1'b1;
      if (r_state == S_IDLE && w_rise)         r_expect <= '0;
      else if (w_wr_ok)                        r_expect <= r_expect + 14'd1;
      if (w_wr_ok && bus.dn_addr == OFF_TYPE)  r_type <= bus.dn_data;
      if (w_wr_ok && bus.dn_addr == OFF_SLO)   r_start[7:0] <= bus.dn_data;
      // Data addresses follow the file offset, so dropped bytes still advance them.
      if (w_wr_ok && bus.dn_addr == OFF_SHI) begin
        r_start[15:8] <= bus.dn_data;
        r_next_addr   <= {bus.dn_data, r_start[7:0]};
      end else if (w_push_req) begin
        r_next_addr <= r_next_addr + 16'd1;
      end
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_count <= w_count_nxt;
      r_pidx  <= (r_state == S_PATCH) ? w_pidx_nxt : 2'd0;
      if (r_state == S_PATCH) r_req <= w_patch_en && (w_pidx_nxt < 2'd2);
      else                    r_req <= (w_count_nxt != '0);
    end
  end

  always_ff @(posedge CLK10MHZ) begin
    if (w_push) begin
      r_fifo_addr[r_wp] <= r_next_addr;
      r_fifo_data[r_wp] <= bus.dn_data;
    end
  end
endmodule

// File: tb/tb_vz_tape_loader.sv
// Bench for vz_tape_loader: scripted and randomized .VZ downloads against a RAM responder.
`timescale 1ns/1ps
module tb_vz_tape_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_hold, load_done, load_err;
  logic [7:0] vz_type;
  logic [2:0] dbg_state;

  int          checks = 0;
  int          failures = 0;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [7:0]  file_q[$];
  int          done_cnt = 0;
  int          done_base = 0;
  bit          hold_seen = 0;
  bit          ack_stall = 0;
  int          ack_lat = 1;
  int          wait_cnt = 0;

  vz_tape_loader_if bus();

  vz_tape_loader #(.FIFO_DEPTH(8)) dut (
    .CLK10MHZ (clk),
    .RESET    (rst_n),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .vz_type  (vz_type),
    .load_done(load_done),
    .load_err (load_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // RAM responder: grants ack_lat cycles after it sees a request, logs each write
  initial begin
    bus.ram_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.ram_ack = 1'b0;
        wait_cnt = 0;
      end else if (bus.ram_ack) begin
        bus.ram_ack = 1'b0;
      end else if (bus.ram_req && !ack_stall) begin
        if (wait_cnt >= ack_lat) begin
          bus.ram_ack = 1'b1;
          obs_q.push_back({bus.ram_addr, bus.ram_data});
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (load_done === 1'b1) done_cnt++;
    if (cpu_hold === 1'b1)  hold_seen = 1;
  end

  // driver tasks
  task automatic build_file(input logic [7:0] typ, input logic [15:0] start, input int n);
    file_q.delete();
    file_q.push_back(8'h56); file_q.push_back(8'h5A);
    file_q.push_back(8'h46); file_q.push_back(8'h30);
    for (int i = 4; i < 21; i++) file_q.push_back(8'($urandom_range(32, 90)));
    file_q.push_back(typ);
    file_q.push_back(start[7:0]);
    file_q.push_back(start[15:8]);
    for (int i = 0; i < n; i++) file_q.push_back(8'($urandom));
  endtask

  task automatic drive_byte(input int off, input logic [7:0] d, input int gap);
    bus.dn_wr   = 1'b1;
    bus.dn_addr = 14'(off);
    bus.dn_data = d;
    @(negedge clk);
    bus.dn_wr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_file(input int gmin, input int gmax, input int skip, input int n_send,
                           input bit drop);
    bus.dn_active = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < file_q.size() && i < n_send; i++)
      if (i != skip) drive_byte(i, file_q[i], $urandom_range(gmin, gmax));
    @(negedge clk);
    if (drop) bus.dn_active = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > base) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_load(input int gmin, input int gmax, input int skip, output bit ok);
    obs_q.delete();
    hold_seen = 0;
    done_base = done_cnt;
    send_file(gmin, gmax, skip, 1 << 20, 1'b1);
    wait_done(done_base, 400, ok);
  endtask

  // reference model: expected RAM writes derived from the file bytes and offsets
  task automatic model(input int skip, input int keep_max, output bit err);
    logic [15:0] start, last;
    logic [7:0]  typ;
    int expect_off, kept, payload;
    exp_q.delete();
    err = 0; expect_off = 0; kept = 0; payload = 0; start = '0; typ = '0;
    for (int i = 0; i < file_q.size(); i++) begin
      if (i == skip) continue;
      if (i != expect_off) begin
        err = 1;
        continue;
      end
      expect_off++;
      if (i == 21)      typ = file_q[i];
      else if (i == 22) start[7:0] = file_q[i];
      else if (i == 23) start[15:8] = file_q[i];
      else if (i >= 24) begin
        payload++;
        if (kept < keep_max) begin
          exp_q.push_back({start + 16'(i - 24), file_q[i]});
          kept++;
        end else begin
          err = 1;
        end
      end
    end
    if (expect_off < 24) begin
      err = 1;
    end else begin
      last = start + 16'(payload);
      if (typ == 8'hF0) begin
        exp_q.push_back({16'h78F9, last[7:0]});
        exp_q.push_back({16'h78FA, last[15:8]});
      end else if (typ == 8'hF1) begin
        exp_q.push_back({16'h788E, start[7:0]});
        exp_q.push_back({16'h788F, start[15:8]});
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    bus.dn_active = 1'b0; bus.dn_wr = 1'b0; bus.dn_addr = '0; bus.dn_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.ram_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.ram_req); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL rst_hold got=%b exp=0", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", load_done); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", load_err); end
    checks++; if (vz_type !== 8'h00) begin failures++; $display("FAIL rst_type got=%h exp=00", vz_type); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_f0_spec();
    bit ok;
    ack_lat = 1;
    build_file(8'hF0, 16'h7AE9, 0);
    file_q.push_back(8'h11); file_q.push_back(8'h22); file_q.push_back(8'h33);
    run_load(2, 2, -1, ok);
    exp_q = {24'h7AE911, 24'h7AEA22, 24'h7AEB33, 24'h78F9EC, 24'h78FA7A};
    checks++; if (!ok) begin failures++; $display("FAIL f0_timeout got=none exp=load_done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL f0_nwrites got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin failures++; $display("FAIL f0_write%0d got=none exp=%h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL f0_write%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== done_base + 1) begin failures++; $display("FAIL f0_pulses got=%0d exp=1", done_cnt - done_base); end
    checks++; if (vz_type !== 8'hF0) begin failures++; $display("FAIL f0_type got=%h exp=f0", vz_type); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL f0_err got=%b exp=0", load_err); end
    checks++; if (cpu_hold !== 1'b0 || hold_seen !== 1'b1) begin failures++; $display("FAIL f0_hold got=%b/%b exp=0/1", cpu_hold, hold_seen); end
  endtask

  task automatic test_f1_spec();
    bit ok;
    ack_lat = 1;
    build_file(8'hF1, 16'hC000, 0);
    file_q.push_back(8'hAA); file_q.push_back(8'hBB);
    run_load(2, 3, -1, ok);
    exp_q = {24'hC000AA, 24'hC001BB, 24'h788E00, 24'h788FC0};
    checks++; if (!ok) begin failures++; $display("FAIL f1_timeout got=none exp=load_done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL f1_nwrites got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin failures++; $display("FAIL f1_write%0d got=none exp=%h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL f1_write%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (vz_type !== 8'hF1) begin failures++; $display("FAIL f1_type got=%h exp=f1", vz_type); end
  endtask

  task automatic test_random();
    bit ok, err;
    logic [7:0] typ;
    for (int t = 0; t < 5; t++) begin
      case ($urandom_range(0, 2))
        0: typ = 8'hF0;
        1: typ = 8'hF1;
        default: typ = 8'h20;
      endcase
      ack_lat = $urandom_range(0, 1);
      build_file(typ, 16'($urandom), $urandom_range(1, 12));
      run_load(2, 4, -1, ok);
      model(-1, 1 << 20, err);
      checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_timeout got=none exp=load_done", t); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd%0d_nwrites got=%0d exp=%0d", t, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= obs_q.size()) begin failures++; $display("FAIL rnd%0d_write%0d got=none exp=%h", t, i, exp_q[i]); end
        else if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_write%0d got=%h exp=%h", t, i, obs_q[i], exp_q[i]); end
      end
      checks++; if (load_err !== err) begin failures++; $display("FAIL rnd%0d_err got=%b exp=%b", t, load_err, err); end
      checks++; if (vz_type !== typ) begin failures++; $display("FAIL rnd%0d_type got=%h exp=%h", t, vz_type, typ); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, err;
    ack_lat = 0;
    ack_stall = 1;
    build_file(8'hF0, 16'h1000, 9);
    obs_q.delete();
    done_base = done_cnt;
    send_file(0, 0, -1, 1 << 20, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (bus.ram_req !== 1'b1 || obs_q.size() != 0) begin failures++; $display("FAIL b2b_stall got=req%b/%0d exp=req1/0", bus.ram_req, obs_q.size()); end
    ack_stall = 0;
    wait_done(done_base, 400, ok);
    model(-1, 8, err);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=none exp=load_done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_nwrites got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin failures++; $display("FAIL b2b_write%0d got=none exp=%h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_write%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL b2b_err got=%b exp=1", load_err); end
  endtask

  task automatic test_wrap();
    bit ok;
    ack_lat = 1;
    build_file(8'hF0, 16'hFFFE, 0);
    file_q.push_back(8'hA0); file_q.push_back(8'hA1); file_q.push_back(8'hA2); file_q.push_back(8'hA3);
    run_load(2, 3, -1, ok);
    exp_q = {24'hFFFEA0, 24'hFFFFA1, 24'h0000A2, 24'h0001A3, 24'h78F902, 24'h78FA00};
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got=none exp=load_done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL wrap_nwrites got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin failures++; $display("FAIL wrap_write%0d got=none exp=%h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_write%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_addr_gap();
    bit ok, err;
    ack_lat = 0;
    build_file(8'hF0, 16'h4000, 9);
    run_load(2, 3, 31, ok);
    model(31, 1 << 20, err);
    checks++; if (!ok) begin failures++; $display("FAIL gap_timeout got=none exp=load_done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL gap_nwrites got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin failures++; $display("FAIL gap_write%0d got=none exp=%h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL gap_write%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (load_err !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL gap_err got=%b exp=1", load_err); end
  endtask

  task automatic test_reset_mid();
    bit ok, err;
    ack_stall = 1;
    build_file(8'hF0, 16'h5000, 8);
    send_file(2, 2, -1, 29, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (bus.ram_req !== 1'b1 || cpu_hold !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b/%b exp=1/1", bus.ram_req, cpu_hold); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ram_req !== 1'b0 || cpu_hold !== 1'b0) begin failures++; $display("FAIL rmid_drop got=%b/%b exp=0/0", bus.ram_req, cpu_hold); end
    @(negedge clk);
    bus.dn_active = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_stall = 0;
    repeat (2) @(negedge clk);
    build_file(8'hF1, 16'($urandom), 5);
    run_load(2, 4, -1, ok);
    model(-1, 1 << 20, err);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got=none exp=load_done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rmid_nwrites got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin failures++; $display("FAIL rmid_write%0d got=none exp=%h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_write%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (load_err !== err) begin failures++; $display("FAIL rmid_err got=%b exp=%b", load_err, err); end
    build_file(8'hF0, 16'h1234, 0);
    while (file_q.size() > 10) void'(file_q.pop_back());
    run_load(1, 2, -1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL short_timeout got=none exp=load_done"); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL short_writes got=%0d exp=0", obs_q.size()); end
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL short_err got=%b exp=1", load_err); end
    checks++; if (cpu_hold !== 1'b0 || done_cnt !== done_base + 1) begin failures++; $display("FAIL short_end got=%b/%0d exp=0/1", cpu_hold, done_cnt - done_base); end
  endtask

  initial begin
    test_reset();
    test_f0_spec();
    test_f1_spec();
    test_random();
    test_back_to_back();
    test_wrap();
    test_addr_gap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
